// File: rtl/cordic_pkg.sv
// Shared formats, constants and FSM encoding for the bit-serial CORDIC blocks.
// Vectors are Q1.14, angles are Q3.13 radians, both 16-bit two's complement.
package cordic_pkg;

  localparam int W      = 16;
  localparam int FRAC_XY = 14;
  localparam int FRAC_Z  = 13;

  localparam logic signed [W-1:0] PI_Q3_13 = 16'sd25736;

  // atan(2^-i) in Q3.13, rounded to nearest
  localparam logic signed [W-1:0] ATAN_LUT_DEFAULT [0:15] = '{
    16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019,
    16'sd511,  16'sd256,  16'sd128,  16'sd64,
    16'sd32,   16'sd16,   16'sd8,    16'sd4,
    16'sd2,    16'sd1,    16'sd0,    16'sd0
  };

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_PREROT = 3'd1;
  localparam state_t ST_SETUP  = 3'd2;
  localparam state_t ST_SERIAL = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/cordic_vectoring_bitserial_if.sv
// Start/busy request bundle for the vectoring CORDIC: operands in, magnitude and angle out.
interface cordic_vectoring_bitserial_if;
  import cordic_pkg::*;

  logic                start;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic                busy;
  logic                done;
  logic signed [W-1:0] mag;
  logic signed [W-1:0] angle;

  modport master (output start, x_in, y_in, input busy, done, mag, angle);
  modport slave  (input start, x_in, y_in, output busy, done, mag, angle);
endinterface

// File: rtl/serial_addsub_cell.sv
// One-bit serial adder/subtractor lane with a registered carry.
// Subtract inverts the operand and injects the +1 on the first bit.
module serial_addsub_cell (
  input  logic clk,
  input  logic reset,
  input  logic a_i,
  input  logic b_i,
  input  logic sub_i,
  input  logic first_i,
  input  logic en_i,
  input  logic clr_i,
  output logic s_o
);
  logic carry_q, carry_d;
  logic b_eff, cin;

  always_comb begin
    b_eff   = b_i ^ sub_i;
    cin     = carry_q | (first_i & sub_i);
    s_o     = a_i ^ b_eff ^ cin;
    carry_d = (a_i & b_eff) | (cin & (a_i ^ b_eff));
  end

  always_ff @(posedge clk) begin
    if (reset || clr_i) carry_q <= 1'b0;
    else if (en_i)      carry_q <= carry_d;
  end
endmodule

// File: rtl/cordic_vectoring_bitserial.sv
// Bit-serial vectoring CORDIC: drives y toward zero, accumulating atan2(y, x) in z
// and leaving the gain-scaled magnitude in x. One iteration = SETUP + 16 serial bits.
module cordic_vectoring_bitserial
  import cordic_pkg::*;
#(
  parameter int                  LENGTH   = 14,
  parameter logic signed [W-1:0] ATAN_LUT [0:15] = ATAN_LUT_DEFAULT,
  parameter logic signed [W-1:0] PI_Q     = PI_Q3_13
) (
  input logic                    clk,
  input logic                    reset,
  cordic_vectoring_bitserial_if.slave bus
);
  localparam logic [4:0] LAST_I = 5'(LENGTH - 1);

  state_t              state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [W-1:0] xs_q, xs_d, ys_q, ys_d, a_q, a_d;
  logic signed [W-1:0] mag_q, mag_d, angle_q, angle_d;
  logic [15:0]         bit_q, bit_d;
  logic [4:0]          i_q, i_d;
  logic                d_q, d_d, busy_q, busy_d, done_q, done_d;
  logic                sx, sy, sz, ser_en, ser_clr;

  assign ser_en  = (state_q == ST_SERIAL);
  assign ser_clr = (state_q == ST_SETUP);

  // d=0: x += ys, y -= xs, z += a; d=1 flips all three
  serial_addsub_cell u_x (.clk(clk), .reset(reset), .a_i(x_q[0]), .b_i(ys_q[0]), .sub_i(d_q),
                          .first_i(bit_q[0]), .en_i(ser_en), .clr_i(ser_clr), .s_o(sx));
  serial_addsub_cell u_y (.clk(clk), .reset(reset), .a_i(y_q[0]), .b_i(xs_q[0]), .sub_i(~d_q),
                          .first_i(bit_q[0]), .en_i(ser_en), .clr_i(ser_clr), .s_o(sy));
  serial_addsub_cell u_z (.clk(clk), .reset(reset), .a_i(z_q[0]), .b_i(a_q[0]), .sub_i(d_q),
                          .first_i(bit_q[0]), .en_i(ser_en), .clr_i(ser_clr), .s_o(sz));

  always_comb begin
    state_d = state_q;
    x_d = x_q;  y_d = y_q;  z_d = z_q;
    xs_d = xs_q; ys_d = ys_q; a_d = a_q;
    mag_d = mag_q; angle_d = angle_q;
    bit_d = bit_q; i_d = i_q; d_d = d_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          busy_d  = 1'b1;
          state_d = ST_PREROT;
        end
      end
      ST_PREROT: begin
        // Left half-plane: rotate by pi so the iterations only see x >= 0
        if (x_q[W-1]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = y_q[W-1] ? -PI_Q : PI_Q;
        end else begin
          z_d = '0;
        end
        i_d     = '0;
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        xs_d    = x_q >>> i_q;
        ys_d    = y_q >>> i_q;
        a_d     = ATAN_LUT[i_q[3:0]];
        d_d     = y_q[W-1];
        bit_d   = 16'h0001;
        state_d = ST_SERIAL;
      end
      ST_SERIAL: begin
        x_d   = {sx, x_q[W-1:1]};
        y_d   = {sy, y_q[W-1:1]};
        z_d   = {sz, z_q[W-1:1]};
        xs_d  = {1'b0, xs_q[W-1:1]};
        ys_d  = {1'b0, ys_q[W-1:1]};
        a_d   = {1'b0, a_q[W-1:1]};
        bit_d = {bit_q[14:0], 1'b0};
        if (bit_q[15]) begin
          i_d     = i_q + 5'd1;
          state_d = (i_q == LAST_I) ? ST_DONE : ST_SETUP;
        end
      end
      ST_DONE: begin
        mag_d   = x_q;
        angle_d = z_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q <= '0;  y_q <= '0;  z_q <= '0;
      xs_q <= '0; ys_q <= '0; a_q <= '0;
      mag_q <= '0; angle_q <= '0;
      bit_q <= '0; i_q <= '0; d_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;  y_q <= y_d;  z_q <= z_d;
      xs_q <= xs_d; ys_q <= ys_d; a_q <= a_d;
      mag_q <= mag_d; angle_q <= angle_d;
      bit_q <= bit_d; i_q <= i_d; d_q <= d_d;
      busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.mag   = mag_q;
  assign bus.angle = angle_q;
endmodule

// File: tb/tb_cordic_vectoring_bitserial.sv
// Directed bench for the vectoring CORDIC: latency, magnitude/angle per quadrant,
// ignored re-start, mid-run reset.
module tb_cordic_vectoring_bitserial;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cordic_vectoring_bitserial_if bus_if();
  cordic_vectoring_bitserial dut (.clk(clk), .reset(reset), .bus(bus_if));

  int n_cmp = 0;
  int n_bad = 0;
  localparam int LAT = 240;

  task automatic start_run(input logic signed [15:0] x, input logic signed [15:0] y);
    @(posedge clk); #1;
    bus_if.x_in  = x;
    bus_if.y_in  = y;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (bus_if.done) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.x_in = '0;
    bus_if.y_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus_if.done); end
    n_cmp++; if (bus_if.mag !== 16'sd0) begin n_bad++; $display("FAIL reset_mag got %0d want 0", bus_if.mag); end
    n_cmp++; if (bus_if.angle !== 16'sd0) begin n_bad++; $display("FAIL reset_angle got %0d want 0", bus_if.angle); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int tx[6]   = '{8000, 0,     -8000, 5000,  -5000,  0};
    int ty[6]   = '{0,    8000,  0,     5000,  -5000,  0};
    int emag[6] = '{13174, 13174, 13174, 11644, 11644, 0};
    int eang[6] = '{0,    12868, 25736, 6434,  -19302, 0};
    int tol[6]  = '{8,    8,     8,     8,     8,      0};
    int cyc, dm, da;
    for (int k = 0; k < 6; k++) begin
      start_run(16'(tx[k]), 16'(ty[k]));
      wait_done(cyc);
      n_cmp++;
      if (cyc != LAT) begin n_bad++; $display("FAIL vec%0d_latency got %0d want %0d", k, cyc, LAT); end
      dm = int'(bus_if.mag) - emag[k];
      n_cmp++;
      if (dm > tol[k] || dm < -tol[k]) begin
        n_bad++; $display("FAIL vec%0d_mag got %0d want %0d+-%0d", k, bus_if.mag, emag[k], tol[k]);
      end
      if (k < 5) begin
        da = int'(bus_if.angle) - eang[k];
        n_cmp++;
        if (da > 8 || da < -8) begin
          n_bad++; $display("FAIL vec%0d_angle got %0d want %0d+-8", k, bus_if.angle, eang[k]);
        end
      end
    end
  endtask

  task automatic test_busy_done();
    int cyc;
    logic signed [15:0] held;
    start_run(16'sd0, 16'sd8000);
    cyc = 0;
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_bad++; $display("FAIL busy_start got %b want 1", bus_if.busy); end
    while (cyc < LAT - 1) begin @(posedge clk); #1; cyc++; end
    n_cmp++; if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
      n_bad++; $display("FAIL pre_done busy/done got %b/%b want 1/0", bus_if.busy, bus_if.done);
    end
    @(posedge clk); #1;
    n_cmp++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b1) begin
      n_bad++; $display("FAIL done_cycle busy/done got %b/%b want 0/1", bus_if.busy, bus_if.done);
    end
    held = bus_if.mag;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got %b want 0", bus_if.done); end
    n_cmp++; if (bus_if.mag - 16'sd13174 > 16'sd8 || bus_if.mag - 16'sd13174 < -16'sd8 || bus_if.mag !== held) begin
      n_bad++; $display("FAIL mag_hold got %0d want 13174+-8 held", bus_if.mag);
    end
  endtask

  task automatic test_restart_ignored();
    int cyc, ndone, first;
    int da, dm;
    start_run(16'sd8000, 16'sd0);
    cyc = 0; ndone = 0; first = -1;
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (bus_if.done) begin ndone++; if (first < 0) first = cyc; end
      if (cyc == 50) begin bus_if.x_in = 16'sd0; bus_if.y_in = 16'sd8000; bus_if.start = 1'b1; end
      if (cyc == 51) bus_if.start = 1'b0;
    end
    n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL restart_done_count got %0d want 1", ndone); end
    n_cmp++; if (first != LAT) begin n_bad++; $display("FAIL restart_latency got %0d want %0d", first, LAT); end
    da = int'(bus_if.angle);
    dm = int'(bus_if.mag) - 13174;
    n_cmp++; if (da > 8 || da < -8) begin n_bad++; $display("FAIL restart_angle got %0d want 0+-8", bus_if.angle); end
    n_cmp++; if (dm > 8 || dm < -8) begin n_bad++; $display("FAIL restart_mag got %0d want 13174+-8", bus_if.mag); end
  endtask

  task automatic test_reset_mid();
    int cyc, ndone, da;
    start_run(16'sd5000, 16'sd5000);
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      n_bad++; $display("FAIL midreset busy/done got %b/%b want 0/0", bus_if.busy, bus_if.done);
    end
    n_cmp++; if (bus_if.mag !== 16'sd0 || bus_if.angle !== 16'sd0) begin
      n_bad++; $display("FAIL midreset mag/angle got %0d/%0d want 0/0", bus_if.mag, bus_if.angle);
    end
    reset = 1'b0;
    ndone = 0;
    repeat (200) begin @(posedge clk); #1; if (bus_if.done) ndone++; end
    n_cmp++; if (ndone != 0 || bus_if.busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_discard dones=%0d busy=%b want 0/0", ndone, bus_if.busy);
    end
    start_run(16'sd0, 16'sd8000);
    wait_done(cyc);
    n_cmp++; if (cyc != LAT) begin n_bad++; $display("FAIL postreset_latency got %0d want %0d", cyc, LAT); end
    da = int'(bus_if.angle) - 12868;
    n_cmp++; if (da > 8 || da < -8) begin n_bad++; $display("FAIL postreset_angle got %0d want 12868+-8", bus_if.angle); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_done();
    test_restart_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cordic_vectoring_bitserial.md
Name: cordic_vectoring_bitserial

Overview:
Bit-serial CORDIC in vectoring mode. It is the inverse companion of the team's bit-serial rotation CORDIC: that block turns an angle into sin/cos, and this one turns an (x, y) vector into a magnitude and an atan2 angle. It sits beside the rotation block in the same datapath. It uses the same 16-bit signed formats, the same start/busy style, and one serial add/sub slice per datapath lane, with 16 bit-cycles per iteration.

Parameters:
LENGTH, 14, number of CORDIC iterations (1..16).
ATAN_LUT, cordic_pkg::ATAN_LUT_DEFAULT, signed 16-bit atan(2^-i) in Q3.13 radians, entries 0..LENGTH-1.
PI_Q, cordic_pkg::PI_Q3_13 (25736), pi in Q3.13, used for left-half-plane pre-rotation.

Ports:
clk  in  1  clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
x_in  in  16  signed Q1.14; |x_in| < 8192 required.
y_in  in  16  signed Q1.14; |y_in| < 8192 required.
busy  out  1  high from the cycle after start is accepted until DONE exits.
done  out  1  one-cycle pulse in the DONE state.
mag  out  16  signed Q1.14, K*sqrt(x²+y²) with K≈1.64676; no gain compensation.
angle  out  16  signed Q3.13 radians, atan2(y, x), range [-pi, pi].

Behaviour:
- Reset (synchronous, active-high) forces:
  - state to IDLE.
  - busy = 0, done = 0, mag = 0, angle = 0.
  - all serial carries cleared.
  - This applies mid-operation too: the in-flight computation is discarded with no done pulse.
- States are IDLE, PREROT, SETUP, SERIAL, DONE.
- IDLE:
  - start = 1 latches x_in/y_in and moves to PREROT.
  - start in any other state is ignored.
- PREROT (1 cycle):
  - If x < 0: x := -x, y := -y, and z := (y_orig >= 0) ? +PI_Q : -PI_Q.
  - Otherwise z := 0.
  - Iteration counter i := 0.
- SETUP (1 cycle):
  - Load xs := x >>> i, ys := y >>> i, a := ATAN_LUT[i].
  - Capture the direction d := y[15].
  - Arm the 16-bit one-hot bit counter.
- SERIAL (16 cycles), LSB first, one bit per cycle per lane:
  - d = 0 (y >= 0): x += ys, y -= xs, z += a.
  - d = 1: x -= ys, y += xs, z -= a.
  - Each lane shifts its result bit into the MSB of its register and shifts its operand right.
  - Subtraction is done by inverting the operand and injecting a carry-in of 1 on bit 0.
  - Carries are cleared at SETUP.
  - After bit 15: i := i+1; go to SETUP if i < LENGTH, otherwise go to DONE.
- DONE (1 cycle):
  - mag := x, angle := z, done = 1.
  - Return to IDLE; busy drops on the same edge.
- Latency: done is high 2 + 17*LENGTH cycles after the edge that samples start (240 for LENGTH=14).
- The next accepted start can be the cycle after done.
- mag and angle hold their value until the next DONE or reset. They never show intermediate values.
- Arithmetic is 16-bit two's complement wrap with no saturation.
- With the input range limit, |mag| < 1.65*8192*sqrt(2) < 2^15, so no overflow.
- Out-of-range inputs give an undefined result but must not hang the FSM.
- x = 0, y = 0 gives mag = 0. angle is whatever the iterations produce (no special case); the bench does not check it.
- y = 0 with x < 0 gives +pi, because y_orig >= 0 selects +PI_Q.

Decomposition:
- cordic_pkg holds:
  - Q-format width constants (16, Q1.14, Q3.13).
  - PI_Q3_13.
  - ATAN_LUT_DEFAULT[0:15].
  - The state enum typedef.
- One sub-module, serial_addsub_cell: 1-bit full adder with operand-invert plus carry-injection for subtract, and a registered carry with synchronous clear. It is instantiated three times (x, y, z lanes).

Test Plan:
- x=8000, y=0 -> done at cycle 240; angle = 0 ±8 LSB; mag = 13174 ±8.
- x=0, y=8000 -> angle = 12868 ±8 (pi/2); mag = 13174 ±8.
- x=-8000, y=0 -> angle = +25736 ±8 (pi, via pre-rotation); mag = 13174 ±8.
- x=5000, y=5000 -> angle = 6434 ±8; mag = 11644 ±8. Then x=-5000, y=-5000 -> angle = -19302 ±8.
- start re-pulsed at cycle 50 of a run with different inputs -> ignored; original result appears at cycle 240, with exactly one done pulse.
- reset asserted at cycle 100 of a run -> next cycle busy = 0, done = 0, mag = 0, angle = 0. A fresh start then completes normally in 240 cycles.
